// File: rtl/seg7_reg_display.sv
// Four-digit multiplexed seven-segment display of a selectable processor register.
// The shown value is snapshotted once per frame (or on reselection) so digits never tear.
module seg7_reg_display #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK       = 4
) (
  input  logic        clk_fpga,
  input  logic        rst,
  input  logic        sel_pulse,
  input  logic [3:0]  pc,
  input  logic [15:0] o_r0,
  input  logic [15:0] o_r1,
  input  logic [15:0] o_r2,
  input  logic [15:0] o_r3,
  input  logic [15:0] o_b,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  sel_idx
);

  localparam int unsigned PW = 16;
  localparam logic [PW-1:0] TERM    = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_C = PW'(BLANK);
  localparam logic [2:0]    SEL_B   = 3'd4;
  localparam logic [2:0]    SEL_PC  = 3'd5;

  logic          run, run_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [1:0]    digit, digit_nxt;
  logic [15:0]   snap, snap_nxt;
  logic          sel_load;
  logic [2:0]    sel_nxt;
  logic [15:0]   src;
  logic          load;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // State register; run is clear only until the first edge after reset.
  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      presc    <= '0;
      digit    <= 2'd0;
      snap     <= 16'h0000;
      sel_idx  <= 3'd0;
      sel_load <= 1'b0;
      an       <= 4'b1111;
      seg      <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      run      <= run_nxt;
      presc    <= presc_nxt;
      digit    <= digit_nxt;
      snap     <= snap_nxt;
      sel_idx  <= sel_nxt;
      sel_load <= sel_pulse;
      an       <= an_nxt;
      seg      <= seg_nxt;
      dp       <= dp_nxt;
    end
  end

  // Next state; loads use the post-edge selection so a pulse on the frame wrap shows the new source.
  always_comb begin
    run_nxt   = 1'b1;
    presc_nxt = presc;
    digit_nxt = digit;
    load      = 1'b0;
    sel_nxt   = sel_idx;
    if (sel_pulse) sel_nxt = (sel_idx == SEL_PC) ? 3'd0 : sel_idx + 3'd1;
    if (!run) begin
      presc_nxt = '0;
      digit_nxt = 2'd0;
      load      = 1'b1;
    end else if (presc == TERM) begin
      presc_nxt = '0;
      digit_nxt = digit + 2'd1;
      load      = (digit == 2'd3);
    end else begin
      presc_nxt = presc + PW'(1);
    end
    if (sel_load) load = 1'b1;
    case (sel_nxt)
      3'd1:    src = o_r1;
      3'd2:    src = o_r2;
      3'd3:    src = o_r3;
      3'd4:    src = o_b;
      3'd5:    src = {12'h000, pc};
      default: src = o_r0;
    endcase
    snap_nxt = load ? src : snap;
  end

  // Output next values; seg/dp only change at slot start, when the anodes are off.
  always_comb begin
    an_nxt  = (presc_nxt < BLANK_C) ? 4'b1111 : ~(4'b0001 << digit_nxt);
    seg_nxt = seg;
    dp_nxt  = dp;
    if (presc_nxt == '0) begin
      if (sel_nxt == SEL_PC && digit_nxt != 2'd0) seg_nxt = 7'h7F;
      else seg_nxt = hex_to_seg(snap_nxt[{digit_nxt, 2'b00} +: 4]);
      dp_nxt = !(sel_nxt == SEL_B && digit_nxt == 2'd0);
    end
  end

endmodule

// File: tb/tb_seg7_reg_display.sv
// Self-checking bench for seg7_reg_display against a cycle-count based display model.
module tb_seg7_reg_display;

  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk_fpga;
  logic        rst;
  logic        sel_pulse;
  logic [3:0]  pc;
  logic [15:0] o_r0, o_r1, o_r2, o_r3, o_b;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  sel_idx;

  seg7_reg_display #(.REFRESH_DIV(DIV), .BLANK(BLK)) dut (
    .clk_fpga (clk_fpga),
    .rst      (rst),
    .sel_pulse(sel_pulse),
    .pc       (pc),
    .o_r0     (o_r0),
    .o_r1     (o_r1),
    .o_r2     (o_r2),
    .o_r3     (o_r3),
    .o_b      (o_b),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .sel_idx  (sel_idx)
  );

  always #5 clk_fpga = ~clk_fpga;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: cycles since reset release, shown value and latched digit image.
  int          cyc;
  int          m_sel;
  logic        m_prev;
  logic [15:0] m_snap;
  logic [6:0]  m_seg;
  logic        m_dp;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s at cyc %0d: observed %h expected %h", tag, cyc, got, exp);
  endtask

  function automatic logic [15:0] src_val(input int s);
    case (s)
      0: return o_r0;
      1: return o_r1;
      2: return o_r2;
      3: return o_r3;
      4: return o_b;
      default: return {12'h000, pc};
    endcase
  endfunction

  task automatic model_reset();
    cyc = -1; m_sel = 0; m_prev = 1'b0; m_snap = 16'h0; m_seg = 7'h7F; m_dp = 1'b1;
  endtask

  task automatic check_all();
    int dig, pos;
    logic [3:0] exp_an;
    if (cyc < 0) exp_an = 4'hF;
    else begin
      pos = cyc % DIV;
      dig = (cyc / DIV) % 4;
      exp_an = (pos < BLK) ? 4'hF : ~(4'(1) << dig);
    end
    check("an", 16'(an), 16'(exp_an));
    check("seg", 16'(seg), 16'(m_seg));
    check("dp", 16'(dp), 16'(m_dp));
    check("sel_idx", 16'(sel_idx), 16'(m_sel));
  endtask

  task automatic tick(input logic pulse);
    int dig;
    logic [3:0] nib;
    sel_pulse = pulse;
    @(posedge clk_fpga);
    if (!rst) begin
      if (pulse) m_sel = (m_sel == 5) ? 0 : m_sel + 1;
      cyc++;
      if ((cyc % FRAME == 0) || m_prev) m_snap = src_val(m_sel);
      m_prev = pulse;
      if (cyc % DIV == 0) begin
        dig   = (cyc / DIV) % 4;
        nib   = 4'((m_snap >> (4 * dig)) & 16'hF);
        m_seg = (m_sel == 5 && dig != 0) ? 7'h7F : hex_tbl[nib];
        m_dp  = !(m_sel == 4 && dig == 0);
      end
    end
    #1;
    sel_pulse = 1'b0;
    check_all();
  endtask

  // Reset is raised between edges so its effect is checked before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_an", 16'(an), 16'hF);
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_dp", 16'(dp), 16'h1);
    check("rst_sel", 16'(sel_idx), 16'h0);
    @(posedge clk_fpga);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_until(input int phase);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (cyc >= 0 && cyc % FRAME == phase) break;
      tick(1'b0);
    end
  endtask

  initial begin
    clk_fpga = 1'b0;
    rst = 1'b1;
    sel_pulse = 1'b0;
    pc = 4'h7;
    o_r0 = 16'h1234; o_r1 = 16'h5678; o_r2 = 16'h9ABC; o_r3 = 16'hDEF0; o_b = 16'hABCD;
    model_reset();
    #2;
    do_reset();

    // Reset release with R0 = 1234: '4' on digit 0 after two blank cycles, full frame of 32.
    repeat (FRAME + 4) tick(1'b0);

    // Step through all six sources, letting a full frame display each.
    for (int k = 0; k < 6; k++) begin
      tick(1'b1);
      repeat (FRAME + 3) tick(1'b0);
    end

    // R0 changes while digit 2 is showing: visible only next frame.
    o_r0 = 16'h0000;
    run_until(FRAME - 1);
    tick(1'b0);
    run_until(2 * DIV + 3);
    o_r0 = 16'hFFFF;
    repeat (2 * FRAME) tick(1'b0);

    // Pulse exactly on the frame wrap edge.
    run_until(FRAME - 1);
    tick(1'b1);
    repeat (FRAME + 2) tick(1'b0);

    // Back-to-back pulses.
    tick(1'b1);
    tick(1'b1);
    repeat (FRAME + 5) tick(1'b0);

    // Randomized sources and pulses.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: o_r0 = 16'($urandom);
          1: o_r1 = 16'($urandom);
          2: o_r2 = 16'($urandom);
          3: o_r3 = 16'($urandom);
          4: o_b  = 16'($urandom);
          default: pc = 4'($urandom);
        endcase
      end
      tick($urandom_range(0, 15) == 0);
    end

    // Asynchronous reset during a lit cycle of digit 2, then the start sequence again.
    o_r0 = 16'h1234;
    run_until(2 * DIV + 4);
    do_reset();
    repeat (FRAME + 4) tick(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_reg_display.md
SEG7_REG_DISPLAY -- requirements
Module: seg7_reg_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clk_fpga cycles per digit slot (legal range 4..65535).
REQ-002 Parameter BLANK, default 4: leading cycles of each slot with all anodes off (legal range 1..REFRESH_DIV-2).
REQ-003 clk_fpga  input  1  system clock; the only clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sel_pulse  input  1  one-cycle pulse (debounced, one-pulsed upstream) advancing the displayed source.
REQ-006 pc  input  4  processor program counter.
REQ-007 o_r0, o_r1, o_r2, o_r3  input  16 each  processor registers R0..R3.
REQ-008 o_b  input  16  processor B register.
REQ-009 an  output  4  digit anodes, active-low, an[0] = rightmost digit.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 sel_idx  output  3  current source index.

Function
REQ-013 sel_idx mapping: 0=R0, 1=R1, 2=R2, 3=R3, 4=B, 5=PC (PC zero-extended to 16 bits).
REQ-014 sel_pulse high on a rising clk_fpga edge increments sel_idx; 5 wraps to 0; values 6..7 are never reached.
REQ-015 Prescaler counts 0..REFRESH_DIV-1 and wraps; the cycle after terminal count starts a new slot and advances digit 0->1->2->3->0.
REQ-016 Snapshot register holds the 16-bit value shown; it loads the selected source when digit wraps 3->0, and on the cycle after any sel_pulse.
REQ-017 When sel_pulse coincides with the 3->0 wrap, the snapshot loads the newly selected source; the prescaler and digit are not disturbed.
REQ-018 Source inputs change mid-frame without effect until the next snapshot load; no digit tearing within a frame.
REQ-019 Digit d shows hex nibble snapshot[4d+3:4d] via a full 0-F decoder: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-020 For the first BLANK cycles of each slot, an=4'b1111; for the remaining cycles, an drives only the active digit low.
REQ-021 seg and dp change only while an=4'b1111 (set at slot start), so no ghosting.
REQ-022 When sel_idx=5, digits 3..1 are blanked (seg=7'h7F) and only digit 0 shows pc.
REQ-023 dp is low only on digit 0 when sel_idx=4 (B marker); otherwise dp=1.
REQ-024 an, seg and dp are driven directly from flops; no combinational path from any input to any output.
REQ-025 Output latency: a snapshot change appears on the affected digit at the first non-blank cycle of that digit's next slot.

Reset
REQ-026 While rst=1: an=4'b1111, seg=7'h7F, dp=1, sel_idx=0, digit=0, prescaler=0, snapshot=0.
REQ-027 On the first edge after rst falls, the design starts slot 0 at prescaler 0 and performs a snapshot load from R0.
REQ-028 rst asserted mid-slot or mid-frame forces the REQ-026 values immediately, without waiting for a clock edge.

Verification (REFRESH_DIV=8, BLANK=2)
REQ-029 Reset release with o_r0=16'h1234 -> an=1111 for 2 cycles, then 1110 with seg=7'h19 ('4') for 6 cycles, then digit 1 shows '3' with an=1101; a full frame spans 32 cycles.
REQ-030 Six sel_pulses from reset with o_b=16'hABCD and pc=4'h7 -> sel_idx steps 1,2,3,4,5,0; at idx 4, digit 0 shows 'd' with dp=0; at idx 5, only digit 0 is lit, showing '7'.
REQ-031 o_r0 changes 16'h0000->16'hFFFF during digit 2 of a frame -> digits 2 and 3 still show '0' this frame; all digits show 'F' next frame.
REQ-032 sel_pulse on the exact 3->0 wrap cycle -> snapshot loads the new source; slot timing shows no stretch or skip.
REQ-033 rst pulsed for 1 cycle during a non-blank cycle of digit 2 -> an=1111 and seg=7'h7F immediately (asynchronously); the REQ-027 sequence restarts.
REQ-034 Back-to-back sel_pulses on consecutive cycles -> sel_idx advances by 2; the snapshot holds the second selection.
